// File: rtl/microwave_ctrl_pkg.sv
// Shared types and constants for the microwave cooking sequencer.
//   state_e   : sequencer states
//   digit_t   : one BCD digit
//   entry_t   : M:SS keypad entry (mins, tens-of-seconds, ones-of-seconds)
//   digit_ok  : keypad filter, true for 0..9
//   entry_ok  : entry may be started (non-zero and tens-of-seconds <= 5)
//   load_digit: digit sent to the timer on LOAD step 0/1/2
package microwave_ctrl_pkg;

    localparam int DIGIT_W   = 4;
    localparam int MAX_TENS  = 5;
    localparam int MAX_DIGIT = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_COOK  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        digit_t mins;
        digit_t tens;
        digit_t ones;
    } entry_t;

    function automatic logic digit_ok(input digit_t d);
        return d <= digit_t'(MAX_DIGIT);
    endfunction

    function automatic logic entry_ok(input entry_t e);
        return (e != '0) && (e.tens <= digit_t'(MAX_TENS));
    endfunction

    // Timer takes the most significant digit first.
    function automatic digit_t load_digit(input entry_t e, input logic [1:0] idx);
        case (idx)
            2'd0:    return e.mins;
            2'd1:    return e.tens;
            default: return e.ones;
        endcase
    endfunction

endpackage

// File: rtl/microwave_ctrl_if.sv
// Sequencer <-> countdown timer connection.
//   timer_data  : digit presented to the timer during load
//   timer_loadn : active-low load strobe, one digit per clk
//   timer_en    : count enable
//   timer_clrn  : active-low one-clk timer clear on cancel
//   timer_zero  : timer reached 0:00
// master = sequencer side, slave = timer side.
interface microwave_ctrl_if;
    import microwave_ctrl_pkg::*;

    digit_t timer_data;
    logic   timer_loadn;
    logic   timer_en;
    logic   timer_clrn;
    logic   timer_zero;

    modport master (
        output timer_data, timer_loadn, timer_en, timer_clrn,
        input  timer_zero
    );

    modport slave (
        input  timer_data, timer_loadn, timer_en, timer_clrn,
        output timer_zero
    );

endinterface

// File: rtl/microwave_ctrl_entry_buffer.sv
// 3-digit BCD keypad entry shift register.
//   clk, clrn  : clock, async active-low reset
//   clear      : synchronous clear to 0:00 (wins over a keypress)
//   shift_en   : sequencer is accepting keys this cycle
//   key_valid  : keypress strobe
//   key_digit  : BCD key; values above 9 are dropped
//   entry      : current M:SS entry
// Each accepted key shifts left, so a 4th digit pushes out the oldest.
module microwave_ctrl_entry_buffer
    import microwave_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   clrn,
    input  logic   clear,
    input  logic   shift_en,
    input  logic   key_valid,
    input  digit_t key_digit,
    output entry_t entry
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            entry <= '0;
        end else if (clear) begin
            entry <= '0;
        end else if (shift_en && key_valid && digit_ok(key_digit)) begin
            entry <= {entry.tens, entry.ones, key_digit};
        end
    end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave cooking sequencer.
//   clk, clrn         : clock, async active-low reset
//   key_valid/digit   : keypad strobe and BCD digit
//   start, stop       : start/resume and pause/cancel levels
//   door_closed       : door interlock
//   tmr               : countdown timer connection (master side)
//   mag_on            : magnetron enable, drops combinationally on door open
//   beep_on           : end-of-cook beeper, BEEP_CYCLES clks
//   entry_err         : one-clk pulse when a start is refused for a bad entry
//   entry_mins/tens/ones : entry buffer for the display
// Input priority: timer_zero > stop > door open > start.
module microwave_ctrl
    import microwave_ctrl_pkg::*;
#(
    parameter int BEEP_CYCLES = 8
) (
    input  logic   clk,
    input  logic   clrn,
    input  logic   key_valid,
    input  digit_t key_digit,
    input  logic   start,
    input  logic   stop,
    input  logic   door_closed,
    microwave_ctrl_if.master tmr,
    output logic   mag_on,
    output logic   beep_on,
    output logic   entry_err,
    output digit_t entry_mins,
    output digit_t entry_tens,
    output digit_t entry_ones
);

    localparam int              BW        = $clog2(BEEP_CYCLES + 1);
    localparam logic [BW-1:0]   BEEP_LAST = BW'(BEEP_CYCLES - 1);

    state_e          state_q, state_d;
    logic [1:0]      load_cnt_q, load_cnt_d;
    logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
    logic            buf_clear;
    logic            buf_shift;
    logic            err_d;
    logic            clr_pulse;
    logic            key_ok;
    entry_t          entry;

    assign key_ok = key_valid && digit_ok(key_digit);

    // While start or stop is held in ENTRY the buffer is frozen, so a start
    // is judged (and loaded) against exactly what the display shows.
    assign buf_shift = (state_q == ST_IDLE) ||
                       ((state_q == ST_ENTRY) && !start && !stop);

    microwave_ctrl_entry_buffer u_entry (
        .clk       (clk),
        .clrn      (clrn),
        .clear     (buf_clear),
        .shift_en  (buf_shift),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .entry     (entry)
    );

    assign entry_mins = entry.mins;
    assign entry_tens = entry.tens;
    assign entry_ones = entry.ones;

    // Door opening must kill the magnetron without waiting for a clock.
    assign mag_on = (state_q == ST_COOK) && door_closed;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
            beep_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        beep_cnt_d = beep_cnt_q;
        buf_clear  = 1'b0;
        err_d      = 1'b0;
        clr_pulse  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_ok) state_d = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    buf_clear = 1'b1;
                end else if (start) begin
                    if (!entry_ok(entry)) begin
                        err_d = 1'b1;
                    end else if (door_closed) begin
                        state_d    = ST_LOAD;
                        load_cnt_d = 2'd0;
                    end
                end
            end
            ST_LOAD: begin
                if (load_cnt_q == 2'd2) begin
                    state_d = door_closed ? ST_COOK : ST_PAUSE;
                end else begin
                    load_cnt_d = load_cnt_q + 2'd1;
                end
            end
            ST_COOK: begin
                if (tmr.timer_zero) begin
                    state_d    = ST_DONE;
                    beep_cnt_d = '0;
                end else if (stop || !door_closed) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    buf_clear = 1'b1;
                    clr_pulse = 1'b1;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop || (beep_cnt_q == BEEP_LAST)) begin
                    state_d   = ST_IDLE;
                    buf_clear = 1'b1;
                end else begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                buf_clear = 1'b1;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up
    // with the state they belong to (e.g. timer_en falls on the edge that
    // leaves COOK).
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            tmr.timer_data  <= '0;
            tmr.timer_loadn <= 1'b1;
            tmr.timer_en    <= 1'b0;
            tmr.timer_clrn  <= 1'b1;
            beep_on         <= 1'b0;
            entry_err       <= 1'b0;
        end else begin
            tmr.timer_data  <= (state_d == ST_LOAD) ? load_digit(entry, load_cnt_d) : '0;
            tmr.timer_loadn <= (state_d != ST_LOAD);
            tmr.timer_en    <= (state_d == ST_COOK);
            tmr.timer_clrn  <= !clr_pulse;
            beep_on         <= (state_d == ST_DONE);
            entry_err       <= err_d;
        end
    end

endmodule

// File: tb/tb_microwave_ctrl.sv
module tb_microwave_ctrl;

    localparam int BEEP = 8;
    localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_COOK = 3, M_PAUSE = 4, M_DONE = 5;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_closed = 1'b1;
    logic       mag_on, beep_on, entry_err;
    logic [3:0] entry_mins, entry_tens, entry_ones;

    microwave_ctrl_if tif ();

    microwave_ctrl #(.BEEP_CYCLES(BEEP)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop        (stop),
        .door_closed (door_closed),
        .tmr         (tif),
        .mag_on      (mag_on),
        .beep_on     (beep_on),
        .entry_err   (entry_err),
        .entry_mins  (entry_mins),
        .entry_tens  (entry_tens),
        .entry_ones  (entry_ones)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase, displayed digits, load step, beeps left.
    int m_mode;
    int m_dig[3];
    int m_ld;
    int m_beep;
    int e_err;
    int e_clrn;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_dig  = '{0, 0, 0};
        m_ld   = 0;
        m_beep = 0;
        e_err  = 0;
        e_clrn = 1;
    endtask

    task automatic model_step(input bit kv, input int kd, input bit st, input bit sp,
                              input bit dc, input bit tz);
        bit key_in;
        key_in = kv && (kd <= 9);
        e_err  = 0;
        e_clrn = 1;
        case (m_mode)
            M_IDLE: if (key_in) begin
                m_dig  = '{0, 0, kd};
                m_mode = M_ENTRY;
            end
            M_ENTRY: begin
                if (sp) begin
                    m_mode = M_IDLE;
                    m_dig  = '{0, 0, 0};
                end else if (st) begin
                    if ((m_dig[0] + m_dig[1] + m_dig[2]) == 0 || m_dig[1] > 5) e_err = 1;
                    else if (dc) begin
                        m_mode = M_LOAD;
                        m_ld   = 0;
                    end
                end else if (key_in) begin
                    m_dig = '{m_dig[1], m_dig[2], kd};
                end
            end
            M_LOAD: begin
                m_ld++;
                if (m_ld == 3) m_mode = dc ? M_COOK : M_PAUSE;
            end
            M_COOK: begin
                if (tz) begin
                    m_mode = M_DONE;
                    m_beep = BEEP;
                end else if (sp || !dc) m_mode = M_PAUSE;
            end
            M_PAUSE: begin
                if (sp) begin
                    m_mode = M_IDLE;
                    m_dig  = '{0, 0, 0};
                    e_clrn = 0;
                end else if (st && dc) m_mode = M_COOK;
            end
            default: begin
                m_beep--;
                if (sp || m_beep == 0) begin
                    m_mode = M_IDLE;
                    m_dig  = '{0, 0, 0};
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("loadn", int'(tif.timer_loadn), int'(m_mode != M_LOAD));
        chk("tdata", int'(tif.timer_data), (m_mode == M_LOAD) ? m_dig[m_ld] : 0);
        chk("ten",   int'(tif.timer_en), int'(m_mode == M_COOK));
        chk("tclrn", int'(tif.timer_clrn), e_clrn);
        chk("mag",   int'(mag_on), int'(m_mode == M_COOK && door_closed));
        chk("beep",  int'(beep_on), int'(m_mode == M_DONE));
        chk("err",   int'(entry_err), e_err);
        chk("entry", int'({entry_mins, entry_tens, entry_ones}),
            m_dig[0] * 256 + m_dig[1] * 16 + m_dig[2]);
    endtask

    // One clock: drive at negedge, check the combinational magnetron gate
    // right away, then check everything just after the rising edge.
    task automatic cycle(input bit kv, input int kd, input bit st, input bit sp,
                         input bit dc, input bit tz);
        @(negedge clk);
        key_valid      = kv;
        key_digit      = 4'(kd);
        start          = st;
        stop           = sp;
        door_closed    = dc;
        tif.timer_zero = tz;
        #1;
        chk("mag_now", int'(mag_on), int'(m_mode == M_COOK && dc));
        model_step(kv, kd, st, sp, dc, tz);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1, 0);
    endtask

    task automatic key(input int d);
        cycle(1, d, 0, 0, 1, 0);
    endtask

    task automatic enter_cook(input int a, input int b, input int c);
        key(a); key(b); key(c);
        cycle(0, 0, 1, 0, 1, 0);
        idle(3);
    endtask

    int  nbeep;
    bit  dc_r;

    initial begin
        tif.timer_zero = 1'b0;
        model_reset();
        #12;
        chk("rst_loadn", int'(tif.timer_loadn), 1);
        chk("rst_clrn",  int'(tif.timer_clrn), 1);
        chk("rst_en",    int'(tif.timer_en), 0);
        chk("rst_data",  int'(tif.timer_data), 0);
        chk("rst_mag",   int'(mag_on), 0);
        chk("rst_beep",  int'(beep_on), 0);
        chk("rst_err",   int'(entry_err), 0);
        chk("rst_entry", int'({entry_mins, entry_tens, entry_ones}), 0);
        @(negedge clk);
        clrn = 1'b1;

        // 4:57 load sequence and cook
        key(4); key(5); key(7);
        chk("entry457", int'({entry_mins, entry_tens, entry_ones}), 'h457);
        cycle(0, 0, 1, 0, 1, 0);
        chk("load0", int'({tif.timer_loadn, tif.timer_data}), 4);
        idle(1);
        chk("load1", int'({tif.timer_loadn, tif.timer_data}), 5);
        idle(1);
        chk("load2", int'({tif.timer_loadn, tif.timer_data}), 7);
        idle(1);
        chk("cook_en",  int'(tif.timer_en), 1);
        chk("cook_mag", int'(mag_on), 1);
        chk("cook_ld",  int'(tif.timer_loadn), 1);

        // door opens mid-cook, then close + start resumes
        cycle(0, 0, 0, 0, 0, 0);
        chk("door_en", int'(tif.timer_en), 0);
        cycle(0, 0, 1, 0, 1, 0);
        chk("resume_en", int'(tif.timer_en), 1);

        // stop -> pause, stop again -> cancel with timer clear pulse
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 1, 0);
        chk("cancel_clrn",  int'(tif.timer_clrn), 0);
        chk("cancel_entry", int'({entry_mins, entry_tens, entry_ones}), 0);
        idle(1);
        chk("clrn_back", int'(tif.timer_clrn), 1);

        // 4-digit entry drops oldest, key 12 ignored
        key(1); key(2); key(3); key(4); key(12);
        chk("entry234", int'({entry_mins, entry_tens, entry_ones}), 'h234);
        cycle(0, 0, 0, 1, 1, 0);

        // 0:00 and 1:75 rejected
        key(0);
        cycle(0, 0, 1, 0, 1, 0);
        chk("err000", int'(entry_err), 1);
        idle(1);
        chk("err_pulse", int'(entry_err), 0);
        key(1); key(7); key(5);
        cycle(0, 0, 1, 0, 1, 0);
        chk("err175", int'(entry_err), 1);
        chk("err175_ld", int'(tif.timer_loadn), 1);
        cycle(0, 0, 0, 1, 1, 0);

        // timer_zero together with stop -> DONE, full beep
        enter_cook(0, 0, 5);
        cycle(0, 0, 0, 1, 1, 1);
        nbeep = int'(beep_on);
        for (int i = 0; i < BEEP + 3; i++) begin
            idle(1);
            nbeep += int'(beep_on);
        end
        chk("beep_len", nbeep, BEEP);

        // stop ends beep early
        enter_cook(0, 1, 0);
        cycle(0, 0, 0, 0, 1, 1);
        idle(2);
        cycle(0, 0, 0, 1, 1, 0);
        chk("beep_stop", int'(beep_on), 0);

        // async reset mid-cook
        enter_cook(1, 0, 0);
        chk("pre_rst_mag", int'(mag_on), 1);
        @(negedge clk);
        #2;
        clrn = 1'b0;
        #1;
        chk("arst_mag",  int'(mag_on), 0);
        chk("arst_en",   int'(tif.timer_en), 0);
        chk("arst_beep", int'(beep_on), 0);
        model_reset();
        @(negedge clk);
        clrn = 1'b1;

        // randomized traffic
        dc_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 5) dc_r = !dc_r;
            cycle($urandom_range(0, 99) < 30, int'($urandom_range(0, 11)),
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
                  dc_r, $urandom_range(0, 99) < 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
